// File: rtl/key_matrix_scan_if.sv
// Key-matrix scanner signal bundle: column drive and row returns toward the matrix,
// debounced key map and press event toward the clock-setting logic.
interface key_matrix_scan_if;
  logic [3:0]  col_sel;
  logic [3:0]  row_in;
  logic [15:0] key_state;
  logic        key_valid;
  logic [3:0]  key_code;

  modport master (
    output col_sel,
    output key_state,
    output key_valid,
    output key_code,
    input  row_in
  );

  modport slave (
    input  col_sel,
    input  key_state,
    input  key_valid,
    input  key_code,
    output row_in
  );
endinterface

// File: rtl/key_matrix_scan.sv
// 4x4 key matrix scanner: steps an active-low column drive, samples synchronized rows,
// debounces whole-matrix frames and reports the lowest newly pressed key as a one-clock event.
module key_matrix_scan #(
  parameter logic [31:0] SCAN_CYCLE      = 32'd50_000,
  parameter logic [7:0]  DEBOUNCE_FRAMES = 8'd5
) (
  input  logic               clk,
  input  logic               rst,
  key_matrix_scan_if.master  bus
);

  localparam int CNT_W = $clog2(SCAN_CYCLE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLE - 32'd1);

  logic [3:0]       sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_sel_q, col_sel_d;
  logic [15:0]      raw_q, raw_d;
  logic [15:0]      prev_q, prev_d;
  logic [7:0]       m_q, m_d;
  logic [15:0]      key_state_q, key_state_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;

  logic        tick;
  logic        frame_end;
  logic        same;
  logic        commit;
  logic [3:0]  rows;
  logic [15:0] frame;
  logic [15:0] new_keys;
  logic [3:0]  low_idx;
  logic [8:0]  m_inc;

  assign rows      = ~sync2_q;
  assign tick      = (cnt_q == CNT_LAST);
  assign frame_end = tick && (col_q == 2'd3);
  // The column-3 nibble joins the frame on the same tick that closes it.
  assign frame     = {rows, raw_q[11:0]};
  assign same      = (frame == prev_q);
  assign m_inc     = {1'b0, m_q} + 9'd1;
  assign commit    = frame_end && same && (m_inc >= {1'b0, DEBOUNCE_FRAMES});
  assign new_keys  = frame & ~key_state_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_raw
      assign raw_d[gi*4 +: 4] = (tick && (col_q == 2'(gi))) ? rows : raw_q[gi*4 +: 4];
    end
  endgenerate

  always_comb begin
    low_idx = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (new_keys[i]) low_idx = 4'(i);
    end
  end

  always_comb begin
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    col_d       = tick ? col_q + 2'd1 : col_q;
    col_sel_d   = ~(4'b0001 << col_d);
    prev_d      = prev_q;
    m_d         = m_q;
    key_state_d = key_state_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    if (frame_end) begin
      prev_d = frame;
      if (same) begin
        m_d = (m_inc >= {1'b0, DEBOUNCE_FRAMES}) ? DEBOUNCE_FRAMES : m_inc[7:0];
      end else begin
        m_d = 8'd0;
      end
    end
    if (commit) begin
      key_state_d = frame;
      if (new_keys != 16'h0) begin
        key_valid_d = 1'b1;
        key_code_d  = low_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 4'b1111;
      sync2_q     <= 4'b1111;
      cnt_q       <= '0;
      col_q       <= 2'd0;
      col_sel_q   <= 4'b1111;
      raw_q       <= 16'h0;
      prev_q      <= 16'h0;
      m_q         <= 8'd0;
      key_state_q <= 16'h0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      sync1_q     <= bus.row_in;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      col_sel_q   <= col_sel_d;
      raw_q       <= raw_d;
      prev_q      <= prev_d;
      m_q         <= m_d;
      key_state_q <= key_state_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign bus.col_sel   = col_sel_q;
  assign bus.key_state = key_state_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_code  = key_code_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: a simulated key pad driven by a held-key mask, directed scenarios
// plus random press/bounce sequences, all checked against a frame-level debounce model.
module tb_key_matrix_scan;

  localparam int SC = 4;
  localparam int DF = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_matrix_scan_if bus ();

  key_matrix_scan #(
    .SCAN_CYCLE      (32'(SC)),
    .DEBOUNCE_FRAMES (8'(DF))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Key pad: row r is pulled low while its key is held and its column is driven low.
  logic [15:0] keys = 16'h0;
  logic [3:0]  rows_drv;
  always_comb begin
    rows_drv = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !bus.col_sel[c]) rows_drv[r] = 1'b0;
  end
  assign bus.row_in = rows_drv;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: whole frames of key snapshots; commit when the last DF+1 frames agree.
  int unsigned edge_n;
  logic [15:0] d1, d2, m_frame, newk;
  logic [15:0] fq[$];
  logic [15:0] exp_state;
  logic        exp_valid;
  logic [3:0]  exp_code;
  logic [3:0]  exp_colsel;
  bit          all_eq;
  int          col;

  task automatic model_reset();
    edge_n     = 0;
    d1         = 16'h0;
    d2         = 16'h0;
    m_frame    = 16'h0;
    fq         = {16'h0};
    exp_state  = 16'h0;
    exp_valid  = 1'b0;
    exp_code   = 4'h0;
    exp_colsel = 4'hF;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      model_reset();
    end else begin
      edge_n++;
      exp_valid = 1'b0;
      if (edge_n % SC == 0) begin
        col = int'((edge_n / SC - 1) % 4);
        m_frame[col*4 +: 4] = d2[col*4 +: 4];
        if (col == 3) begin
          fq.push_back(m_frame);
          if (fq.size() > DF + 1) void'(fq.pop_front());
          all_eq = (fq.size() == DF + 1);
          foreach (fq[i]) if (fq[i] != fq[0]) all_eq = 1'b0;
          if (all_eq) begin
            newk = m_frame & ~exp_state;
            exp_state = m_frame;
            if (newk != 16'h0) begin
              exp_valid = 1'b1;
              for (int i = 15; i >= 0; i--) if (newk[i]) exp_code = 4'(i);
            end
          end
        end
      end
      exp_colsel = ~(4'b0001 << ((edge_n / SC) % 4));
      d2 = d1;
      d1 = keys;
    end
  end

  bit   chk_en = 1'b0;
  int   pulse_cnt = 0;
  logic [3:0] last_code = 4'h0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst) begin
        check("rst_col_sel", 32'(bus.col_sel), 32'hF);
        check("rst_key_state", 32'(bus.key_state), 32'h0);
        check("rst_key_valid", 32'(bus.key_valid), 32'h0);
        check("rst_key_code", 32'(bus.key_code), 32'h0);
      end else begin
        check("col_sel", 32'(bus.col_sel), 32'(exp_colsel));
        check("key_state", 32'(bus.key_state), 32'(exp_state));
        check("key_valid", 32'(bus.key_valid), 32'(exp_valid));
        check("key_code", 32'(bus.key_code), 32'(exp_code));
        check("valid_gap", 32'(bus.key_valid & prev_valid), 32'h0);
        if (bus.key_valid) begin
          pulse_cnt++;
          last_code = bus.key_code;
          $display("event t=%0t code=%0d state=%04h", $time, bus.key_code, bus.key_state);
        end
      end
      prev_valid = bus.key_valid;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    #2 rst = 1'b0;
    chk_en = 1'b1;
    clks(3);
    check("reset_state", 32'(bus.key_state), 32'h0);
    check("reset_col_sel", 32'(bus.col_sel), 32'hF);
    rst = 1'b1;
    clks(1);
    check("first_col", 32'(bus.col_sel), 32'hE);

    // 1: idle scanning
    base = pulse_cnt;
    clks(80);
    check("idle_pulses", 32'(pulse_cnt - base), 32'd0);
    check("idle_state", 32'(bus.key_state), 32'h0);

    // 2: single held key
    base = pulse_cnt;
    keys = 16'h0040;
    clks(96);
    check("k6_pulses", 32'(pulse_cnt - base), 32'd1);
    check("k6_code", 32'(last_code), 32'd6);
    check("k6_state", 32'(bus.key_state), 32'h0040);
    clks(80);
    check("k6_no_repeat", 32'(pulse_cnt - base), 32'd1);

    // 3: bounce then steady
    keys = 16'h0;
    clks(96);
    base = pulse_cnt;
    for (int i = 0; i < 8; i++) begin
      keys = keys ^ 16'h0040;
      clks(5);
    end
    check("bounce_pulses", 32'(pulse_cnt - base), 32'd0);
    keys = 16'h0040;
    clks(96);
    check("bounce_pulse", 32'(pulse_cnt - base), 32'd1);
    check("bounce_code", 32'(last_code), 32'd6);

    // 4: simultaneous presses, then partial release
    keys = 16'h0;
    clks(96);
    base = pulse_cnt;
    keys = 16'h0208;
    clks(96);
    check("dual_pulses", 32'(pulse_cnt - base), 32'd1);
    check("dual_code", 32'(last_code), 32'd3);
    check("dual_state", 32'(bus.key_state), 32'h0208);
    keys = 16'h0200;
    clks(96);
    check("rel_state", 32'(bus.key_state), 32'h0200);
    check("rel_pulses", 32'(pulse_cnt - base), 32'd1);

    // 5: reset mid-frame while key 15 is held
    keys = 16'h0;
    clks(96);
    keys = 16'h8000;
    clks(30);
    rst = 1'b0;
    #1;
    check("mid_rst_col_sel", 32'(bus.col_sel), 32'hF);
    check("mid_rst_state", 32'(bus.key_state), 32'h0);
    check("mid_rst_valid", 32'(bus.key_valid), 32'h0);
    check("mid_rst_code", 32'(bus.key_code), 32'h0);
    clks(3);
    base = pulse_cnt;
    rst = 1'b1;
    clks(96);
    check("k15_pulses", 32'(pulse_cnt - base), 32'd1);
    check("k15_code", 32'(last_code), 32'hF);
    check("k15_state", 32'(bus.key_state), 32'h8000);

    // 6: add a key while another is committed
    keys = 16'h0;
    clks(96);
    keys = 16'h0001;
    clks(96);
    base = pulse_cnt;
    keys = 16'h0021;
    clks(96);
    check("add_pulses", 32'(pulse_cnt - base), 32'd1);
    check("add_code", 32'(last_code), 32'd5);
    check("add_state", 32'(bus.key_state), 32'h0021);

    // Random presses, releases and bounces
    for (int it = 0; it < 40; it++) begin
      logic [15:0] target;
      target = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        for (int b = 0; b < int'($urandom_range(2, 8)); b++) begin
          keys = keys ^ 16'($urandom);
          clks(int'($urandom_range(1, 9)));
        end
      end
      keys = target;
      clks(int'($urandom_range(10, 120)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_matrix_scan.md
Name: key_matrix_scan

Overview:
- Input-side counterpart to the time-multiplexed seven-segment scanner: scans a 4x4 key matrix and delivers debounced key events to the clock-setting logic.
- Column drive is active-low one-hot, stepped on a fixed tick; row returns are active-low with external pull-ups.
- Produces a debounced 16-bit key state, plus a one-clock press event carrying a 4-bit key code.

Parameters:
- SCAN_CYCLE, 32'd50_000, clocks per column step (1 ms at 50 MHz); legal range >= 4.
- DEBOUNCE_FRAMES, 8'd5, consecutive identical full-matrix frames beyond the first needed to commit; legal range >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- col_sel  output  4  column drive, active-low one-hot.
- row_in  input  4  row returns, active-low, asynchronous to clk.
- key_state  output  16  debounced pressed map, 1 = pressed; bit index = col*4 + row.
- key_valid  output  1  one-clock pulse on a newly committed press.
- key_code  output  4  index of the reported press; holds its value between pulses.

Behaviour:
- Reset values: col_sel=4'b1111; key_state=16'h0; key_valid=0; key_code=4'h0.
- Reset also clears the tick counter, column index, raw frame, previous frame, match counter and synchronizer (synchronizer cleared to 4'b1111).
- Reset asserted mid-scan aborts the frame immediately; no event is emitted.
- First clock after reset release: col_sel=4'b1110 (column 0).
- row_in passes through a 2-flop synchronizer and is inverted internally, so 1 = pressed.
- Tick counter runs 0..SCAN_CYCLE-1 and wraps.
- On a tick (count == SCAN_CYCLE-1):
  - the synchronized rows are stored into raw[col*4 +: 4];
  - col advances 0->1->2->3->0;
  - col_sel = ~(1<<col), registered;
  - sampling happens at the end of the column period, so the drive has settled for SCAN_CYCLE-2 clocks.
- Frame end = the tick that samples column 3. The frame value includes the nibble sampled on that same tick. At frame end:
  - if frame == prev: m <= min(m+1, DEBOUNCE_FRAMES); otherwise m <= 0;
  - prev <= frame;
  - if frame == prev and m+1 >= DEBOUNCE_FRAMES: commit.
- Commit, registered on the same edge:
  - key_state <= frame;
  - new = frame & ~key_state;
  - if new != 0: key_valid=1 for exactly one clock, and key_code = lowest set bit index of new.
- Simultaneous new presses in one commit: only the lowest index is reported; the others appear in key_state only and are never reported later.
- Releases update key_state on commit; no event is emitted.
- A held key produces no repeat event.
- Any mismatching frame (bounce) resets m to 0; key_state holds its last committed value.
- key_valid is never asserted in two consecutive clocks (commits are at least 4*SCAN_CYCLE apart).
- Ghosting and masking with three or more keys: no detection; the raw matrix is reported as-is.
- Latency from a stable press to key_valid: between DEBOUNCE_FRAMES+1 and DEBOUNCE_FRAMES+2 frames plus 2 clocks (one frame = 4*SCAN_CYCLE clocks).

Test Plan (SCAN_CYCLE=4, DEBOUNCE_FRAMES=3; bench model pulls row r low while col_sel[c]=0 for each held key):
1. Reset, then release; no keys held -> col_sel = 1110, 1101, 1011, 0111 repeating, 4 clocks each; key_state=0; key_valid never asserts.
2. Hold key (col 1, row 2) from t0 -> exactly one key_valid pulse, key_code=4'd6, key_state=16'h0040, within 96 clocks of t0; no further pulses while held.
3. Key 6 bounces (toggles every 5 clocks for 40 clocks), then held steady -> no pulse during bounce; single pulse with key_code=6 within 96 clocks of the last toggle.
4. Press keys 9 and 3 simultaneously -> one pulse, key_code=3, key_state=16'h0208. Then release key 3 -> key_state=16'h0200 after debounce, no pulse.
5. Hold key 15; assert rst mid-frame for 3 clocks, then release while the key is still held -> outputs return to reset values at once; after release, a fresh press event with key_code=4'hF is reported.
6. With key 0 committed, add key 5 -> pulse with key_code=5 (key 0 not re-reported); key_state=16'h0021.
